bp_update_ctrl: RTL

BP_UPDATE_CTRL -- requirements
Module: bp_update_ctrl

---
 rtl/bp_update_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/bp_update_ctrl.sv
// Branch-resolution update controller: mispredict redirect, 2-bit BHT training,
// and a small circular FIFO that serialises BTB writes one per cycle.
module bp_update_ctrl #(
  parameter int FIFO_DEPTH   = 4,
  parameter int BHT_ADDR_LEN = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_PC,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_PC,
  output logic        redirect,
  output logic [31:0] redirect_PC,
  output logic        wr_req,
  output logic [31:0] wr_PC,
  output logic [31:0] wr_predicted_PC,
  output logic        wr_predicted_state_bit,
  output logic [31:0] br_count,
  output logic [31:0] mis_count
);

  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BHT_N = 1 << BHT_ADDR_LEN;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        st;
  } entry_t;

  entry_t                  fifo_q [FIFO_DEPTH];
  logic [PW-1:0]           rd_ptr_q, wr_ptr_q;
  logic [PW:0]             cnt_q, cnt_d;
  logic [1:0]              bht_q [BHT_N];

  logic                    redirect_q;
  logic [31:0]             redirect_pc_q, redirect_pc_d;
  logic                    wr_req_q;
  logic [31:0]             wr_pc_q, wr_tgt_q;
  logic                    wr_st_q;
  logic [31:0]             br_cnt_q, mis_cnt_q;

  logic                    accept, mispredict, push, pop, new_state;
  logic [BHT_ADDR_LEN-1:0] idx;
  logic [1:0]              ctr_cur, ctr_d;
  entry_t                  push_entry;

  // Readiness looks only at registered occupancy, so a same-cycle pop never frees a slot.
  assign ex_ready = (cnt_q < (PW+1)'(FIFO_DEPTH));
  assign accept   = ex_valid && ex_ready;

  assign idx     = ex_PC[BHT_ADDR_LEN+1:2];
  assign ctr_cur = bht_q[idx];

  always_comb begin
    ctr_d = ctr_cur;
    if (ex_taken) begin
      if (ctr_cur != 2'b11) ctr_d = ctr_cur + 2'b01;
    end else begin
      if (ctr_cur != 2'b00) ctr_d = ctr_cur - 2'b01;
    end
  end

  assign new_state  = ctr_d[1];
  assign mispredict = accept &&
                      ((ex_pred_taken != ex_taken) || (ex_taken && (ex_pred_PC != ex_target)));
  assign push       = accept &&
                      ((new_state != ex_pred_taken) || (new_state && (ex_pred_PC != ex_target)));
  assign pop        = (cnt_q != '0);

  assign redirect_pc_d = ex_taken ? ex_target : (ex_PC + 32'd4);
  assign cnt_d         = cnt_q + (PW+1)'(push) - (PW+1)'(pop);

  assign push_entry.pc  = ex_PC;
  assign push_entry.tgt = ex_target;
  assign push_entry.st  = new_state;

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      cnt_q         <= '0;
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      wr_req_q      <= 1'b0;
      wr_pc_q       <= '0;
      wr_tgt_q      <= '0;
      wr_st_q       <= 1'b0;
      br_cnt_q      <= '0;
      mis_cnt_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      redirect_q <= mispredict;
      if (mispredict) redirect_pc_q <= redirect_pc_d;
      if (accept) begin
        bht_q[idx] <= ctr_d;
        br_cnt_q   <= br_cnt_q + 32'd1;
      end
      if (mispredict) mis_cnt_q <= mis_cnt_q + 32'd1;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      // Head leaves the FIFO this cycle and is presented on the BTB port next cycle.
      wr_req_q <= pop;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        wr_pc_q  <= fifo_q[rd_ptr_q].pc;
        wr_tgt_q <= fifo_q[rd_ptr_q].tgt;
        wr_st_q  <= fifo_q[rd_ptr_q].st;
      end
    end
  end

  assign redirect               = redirect_q;
  assign redirect_PC            = redirect_pc_q;
  assign wr_req                 = wr_req_q;
  assign wr_PC                  = wr_pc_q;
  assign wr_predicted_PC        = wr_tgt_q;
  assign wr_predicted_state_bit = wr_st_q;
  assign br_count               = br_cnt_q;
  assign mis_count              = mis_cnt_q;

endmodule
